// File: rtl/bar_value_conditioner_if.sv
// Sample-stream handshake between a raw sample producer and bar_value_conditioner.
interface bar_value_conditioner_if;
    logic [11:0] sample;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/bar_value_conditioner.sv
// Boxcar-averages 12-bit samples, scales to pixels with a shift-add multiplier and latches the
// result on vsync rising edges. Optional macro PEAK_HOLD_EN adds peak hold with linear decay.
module bar_value_conditioner #(
    parameter int unsigned X_BITS      = 13,
`ifdef PEAK_HOLD_EN
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned DECAY_STEP  = 4,
`endif
    parameter int unsigned AVG_LOG2    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    bar_value_conditioner_if.slave  smp,
    input  logic                    vsync,
    input  logic [X_BITS-1:0]       total_active_pix,
    output logic [11:0]             bar_len,
    output logic                    frame_tick
);
    localparam int unsigned SUM_W  = 12 + AVG_LOG2;
    localparam int unsigned PROD_W = 12 + X_BITS;
    localparam int unsigned CNT_W  = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {StAcc, StMul, StDone} state_e;

    state_e              state;
    logic [SUM_W-1:0]    sum;
    logic [CNT_W-1:0]    count;
    logic [11:0]         mplier;
    logic [PROD_W-1:0]   mcand;
    logic [PROD_W-1:0]   product;
    logic [3:0]          iter;
    logic [11:0]         pending;
    logic                pending_valid;
    logic                vsync_d;

    logic                accept;
    logic                vsync_edge;
    logic [SUM_W-1:0]    sum_next;
    logic [11:0]         avg_next;
    logic [X_BITS-1:0]   scaled;
    logic [11:0]         result;

    assign smp.sample_ready = (state == StAcc) && !rst;
    assign accept     = smp.sample_valid && smp.sample_ready;
    assign vsync_edge = vsync && !vsync_d;
    assign sum_next   = sum + SUM_W'(smp.sample);
    assign avg_next   = sum_next[SUM_W-1:AVG_LOG2];
    assign scaled     = product[PROD_W-1:12];
    assign result     = (32'(scaled) > 32'd4095) ? 12'hfff : 12'(scaled);

`ifdef PEAK_HOLD_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 2);

    logic [HOLD_W-1:0] hold;
    logic [11:0]       live;
    logic [11:0]       live_now;
    logic [11:0]       decayed;
    logic [11:0]       peak_dec;

    // bar_len doubles as the peak register; decay never drops below the live value.
    assign live_now = pending_valid ? pending : live;
    assign decayed  = (bar_len >= 12'(DECAY_STEP)) ? bar_len - 12'(DECAY_STEP) : 12'd0;
    assign peak_dec = (decayed > live_now) ? decayed : live_now;
`endif

    always_ff @(posedge clk) begin
        vsync_d <= vsync;
        if (rst) begin
            state         <= StAcc;
            sum           <= '0;
            count         <= '0;
            mplier        <= '0;
            mcand         <= '0;
            product       <= '0;
            iter          <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            bar_len       <= '0;
            frame_tick    <= 1'b0;
`ifdef PEAK_HOLD_EN
            hold          <= '0;
            live          <= '0;
`endif
        end else begin
            frame_tick <= vsync_edge;

            // Edge logic runs first so a same-cycle DONE re-arms pending for the next frame.
            if (vsync_edge) begin
`ifdef PEAK_HOLD_EN
                if (pending_valid) begin
                    live <= pending;
                end
                if (pending_valid && pending >= bar_len) begin
                    bar_len <= pending;
                    hold    <= HOLD_W'(HOLD_FRAMES);
                end else if (hold != '0) begin
                    hold <= hold - 1'b1;
                end else begin
                    bar_len <= peak_dec;
                end
`else
                if (pending_valid) begin
                    bar_len <= pending;
                end
`endif
                pending_valid <= 1'b0;
            end

            unique case (state)
                StAcc: begin
                    if (accept) begin
                        if (count == CNT_LAST) begin
                            mplier  <= avg_next;
                            mcand   <= PROD_W'(total_active_pix);
                            product <= '0;
                            iter    <= '0;
                            sum     <= '0;
                            count   <= '0;
                            state   <= StMul;
                        end else begin
                            sum   <= sum_next;
                            count <= count + 1'b1;
                        end
                    end
                end
                StMul: begin
                    if (mplier[0]) begin
                        product <= product + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    iter   <= iter + 4'd1;
                    if (iter == 4'd11) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    pending       <= result;
                    pending_valid <= 1'b1;
                    state         <= StAcc;
                end
                default: state <= StAcc;
            endcase
        end
    end
endmodule

// File: tb/tb_bar_value_conditioner.sv
// Scoreboard bench: expected bar_len values are queued per vsync pulse and checked on frame_tick.
module tb_bar_value_conditioner;
    localparam int unsigned X_BITS = 13;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vsync = 1'b0;
    logic [X_BITS-1:0] total_active_pix = '0;
    logic [11:0]       bar_len;
    logic              frame_tick;

    int          vectors = 0;
    int          miscompares = 0;
    logic [11:0] exp_q[$];

    bar_value_conditioner_if smp ();

    bar_value_conditioner #(
        .X_BITS   (X_BITS),
        .AVG_LOG2 (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .smp              (smp),
        .vsync            (vsync),
        .total_active_pix (total_active_pix),
        .bar_len          (bar_len),
        .frame_tick       (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic send_sample(input logic [11:0] v);
        int n;
        n = 0;
        while (smp.sample_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 50) check("ready_timeout", 32'(smp.sample_ready), 1);
        smp.sample       = v;
        smp.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        smp.sample_valid = 1'b0;
    endtask

    task automatic send_window(input logic [X_BITS-1:0] tap, input logic [11:0] a,
                               input logic [11:0] b, input logic [11:0] c, input logic [11:0] d);
        total_active_pix = tap;
        send_sample(a);
        send_sample(b);
        send_sample(c);
        send_sample(d);
    endtask

    task automatic vsync_pulse(input int hi);
        vsync = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: every frame_tick must match the oldest queued expectation.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (!rst && frame_tick) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_tick: bar_len=%0d with nothing expected", bar_len);
                end else begin
                    e = exp_q.pop_front();
                    if (bar_len !== e) begin
                        miscompares++;
                        $display("FAIL bar_len_on_tick: got %0d, expected %0d", bar_len, e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
        $fatal(1);
    end

    initial begin
        smp.sample       = '0;
        smp.sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bar_len", 32'(bar_len), 0);
        check("rst_frame_tick", 32'(frame_tick), 0);
        check("rst_ready", 32'(smp.sample_ready), 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(smp.sample_ready), 1);

        // Full scale: 4095*1280/4096 = 1279
        send_window(1280, 4095, 4095, 4095, 4095);
        repeat (14) @(posedge clk);
        #1;
        exp_q.push_back(12'd1279);
        vsync_pulse(2);

        // Half scale: avg 2048, 2048*1920/4096 = 960
        send_window(1920, 2048, 2048, 2049, 2047);
        repeat (14) @(posedge clk);
        #1;
        exp_q.push_back(12'd960);
        vsync_pulse(2);

        // No new data: long vsync gives one tick, bar_len holds
        exp_q.push_back(12'd960);
        vsync_pulse(100);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(12'd960);
            vsync_pulse(5);
        end

        // Truncating average: (1+2+3+4)>>2 = 2
        send_window(4096, 1, 2, 3, 4);
        repeat (14) @(posedge clk);
        #1;
        exp_q.push_back(12'd2);
        vsync_pulse(2);

        // Saturation: 4095*8191/4096 = 8189 -> 4095
        send_window(8191, 4095, 4095, 4095, 4095);
        repeat (14) @(posedge clk);
        #1;
        exp_q.push_back(12'd4095);
        vsync_pulse(2);

        // Backpressure during MUL/DONE; the 3000 window is then overwritten by 400*2048/4096
        total_active_pix = 1000;
        smp.sample       = 12'd3000;
        smp.sample_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        smp.sample = 12'd4095;
        for (int i = 0; i < 13; i++) begin
            check("mul_ready_low", 32'(smp.sample_ready), 0);
            @(posedge clk);
            #1;
        end
        check("ready_back_high", 32'(smp.sample_ready), 1);
        smp.sample_valid = 1'b0;
        send_window(2048, 400, 400, 400, 400);
        repeat (14) @(posedge clk);
        #1;
        exp_q.push_back(12'd200);
        vsync_pulse(2);

        // Edge coincides with DONE: edge sees no pending, new result waits for next frame
        send_window(4096, 1000, 1000, 1000, 1000);
        repeat (12) @(posedge clk);
        #1;
        exp_q.push_back(12'd200);
        vsync_pulse(3);
        exp_q.push_back(12'd1000);
        vsync_pulse(2);

        // Reset during MUL discards the window
        send_window(1280, 4095, 4095, 4095, 4095);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midmul_rst_bar_len", 32'(bar_len), 0);
        check("midmul_rst_ready", 32'(smp.sample_ready), 0);
        check("midmul_rst_tick", 32'(frame_tick), 0);
        rst = 1'b0;
        #1;
        check("midmul_ready_after", 32'(smp.sample_ready), 1);
        repeat (15) @(posedge clk);
        #1;
        exp_q.push_back(12'd0);
        vsync_pulse(2);
        send_window(4096, 1000, 1000, 1000, 1000);
        repeat (14) @(posedge clk);
        #1;
        exp_q.push_back(12'd1000);
        vsync_pulse(2);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
